// File: rtl/disp_scan_pkg.sv
// Shared constants, types and anode decode for the 4-digit 7-segment scan path.
package disp_scan_pkg;

   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned NIB_W      = 4;
   localparam int unsigned SEL_W      = 2;

   localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

   typedef logic [NIB_W-1:0] nib_t;
   typedef logic [SEL_W-1:0] sel_t;

   // Active-low enable for the selected digit; a blanked digit stays dark.
   function automatic logic [NUM_DIGITS-1:0] an_decode(input sel_t sel,
                                                       input logic [NUM_DIGITS-1:0] mask);
      logic [NUM_DIGITS-1:0] an;
      an      = AN_OFF;
      an[sel] = mask[sel];
      return an;
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running DIV_W-bit scan prescaler. wrap_o flags the cycle whose edge
// advances the digit select. hold_i freezes the count and suppresses wrap_o.
module scan_prescaler #(
   parameter int unsigned DIV_W = 17
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic hold_i,
   output logic wrap_o
);

   logic [DIV_W-1:0] div_q, div_d;

   // Next count and wrap flag.
   always_comb begin
      div_d  = div_q;
      wrap_o = 1'b0;
      if (!hold_i) begin
         div_d  = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
         wrap_o = (div_q == {DIV_W{1'b1}});
      end
   end

   // Counter state with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Scan controller for the 4-digit 7-segment display: latches the hex word and
// blank mask, steps the mux select from the prescaler, and decodes the anodes.
// Optional feature macro: SCAN_HOLD_EN adds the hold input that freezes scanning.
module disp_scan_ctrl
   import disp_scan_pkg::*;
#(
   parameter int unsigned DIV_W = 17
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [15:0]           hex,
   input  logic [NUM_DIGITS-1:0] blank_mask,
`ifdef SCAN_HOLD_EN
   input  logic                  hold,
`endif
   output logic [NIB_W-1:0]      I0,
   output logic [NIB_W-1:0]      I1,
   output logic [NIB_W-1:0]      I2,
   output logic [NIB_W-1:0]      I3,
   output logic [SEL_W-1:0]      s,
   output logic [NUM_DIGITS-1:0] an,
   output logic                  tick
);

   logic                                  hold_w;
   logic                                  wrap;
   sel_t                                  s_q, s_d;
   logic                                  tick_q, tick_d;
   logic [NUM_DIGITS-1:0][NIB_W-1:0]      nib_q, nib_d;
   logic [NUM_DIGITS-1:0]                 mask_q, mask_d;

`ifdef SCAN_HOLD_EN
   assign hold_w = hold;
`else
   assign hold_w = 1'b0;
`endif

   scan_prescaler #(
      .DIV_W (DIV_W)
   ) u_prescaler (
      .clk_i  (clk),
      .rst_i  (rst),
      .hold_i (hold_w),
      .wrap_o (wrap)
   );

   // Next-state for select, tick and the load registers; load and advance are independent.
   always_comb begin
      s_d    = wrap ? s_q + 2'd1 : s_q;
      tick_d = wrap;
      nib_d  = nib_q;
      mask_d = mask_q;
      if (load) begin
         nib_d  = hex;
         mask_d = blank_mask;
      end
   end

   // Registers with synchronous reset taking priority over load and advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q    <= '0;
         tick_q <= 1'b0;
         nib_q  <= '0;
         mask_q <= '0;
      end else begin
         s_q    <= s_d;
         tick_q <= tick_d;
         nib_q  <= nib_d;
         mask_q <= mask_d;
      end
   end

   // Outputs; the anode decode is combinational so it tracks s with no lag.
   always_comb begin
      I0   = nib_q[0];
      I1   = nib_q[1];
      I2   = nib_q[2];
      I3   = nib_q[3];
      s    = s_q;
      tick = tick_q;
      an   = an_decode(s_q, mask_q);
   end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl with DIV_W=2 (4 cycles per digit).
// Directed vector table, hand sequences for reset/hold, then random stimulus
// against a count-based reference model.
module tb_disp_scan_ctrl;

   localparam int unsigned DivW = 2;
   localparam int unsigned Dwell = 1 << DivW;
`ifdef SCAN_HOLD_EN
   localparam bit HoldEn = 1'b1;
`else
   localparam bit HoldEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, load, hold;
   logic [15:0] hex;
   logic [3:0]  blank_mask;
   logic [3:0]  I0, I1, I2, I3;
   logic [1:0]  s;
   logic [3:0]  an;
   logic        tick;

   int checks = 0;
   int errors = 0;

   // Reference model: counted scan edges since reset, plus captured data.
   int          m_n;
   logic        m_tick;
   logic [15:0] m_word;
   logic [3:0]  m_mask;

   always #5 clk = ~clk;

   disp_scan_ctrl #(
      .DIV_W (DivW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .hex        (hex),
      .blank_mask (blank_mask),
`ifdef SCAN_HOLD_EN
      .hold       (hold),
`endif
      .I0         (I0),
      .I1         (I1),
      .I2         (I2),
      .I3         (I3),
      .s          (s),
      .an         (an),
      .tick       (tick)
   );

   typedef struct {
      logic        rst;
      logic        load;
      logic [15:0] hex;
      logic [3:0]  mask;
      logic [1:0]  exp_s;
      logic [3:0]  exp_an;
      logic [15:0] exp_word;
      logic        exp_tick;
   } vec_t;

   vec_t vecs[19];

   function automatic vec_t mk(input logic r, input logic l, input logic [15:0] h,
                               input logic [3:0] m, input logic [1:0] es,
                               input logic [3:0] ea, input logic [15:0] ew,
                               input logic et);
      vec_t v;
      v.rst = r; v.load = l; v.hex = h; v.mask = m;
      v.exp_s = es; v.exp_an = ea; v.exp_word = ew; v.exp_tick = et;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] m_s();
      return 2'((m_n / Dwell) % 4);
   endfunction

   function automatic logic [3:0] m_an();
      logic [1:0] sel;
      sel = m_s();
      if (m_mask[sel]) return 4'b1111;
      return ~(4'b0001 << sel);
   endfunction

   // One clock: drive at the falling edge, update the model at the rising edge,
   // return at the next falling edge where outputs are stable.
   task automatic step(input logic r, input logic l, input logic [15:0] h,
                       input logic [3:0] m, input logic hd);
      rst = r; load = l; hex = h; blank_mask = m; hold = hd;
      @(posedge clk);
      if (r) begin
         m_n = 0; m_tick = 1'b0; m_word = '0; m_mask = '0;
      end else begin
         if (HoldEn && hd) begin
            m_tick = 1'b0;
         end else begin
            m_tick = ((m_n % Dwell) == Dwell - 1);
            m_n++;
         end
         if (l) begin
            m_word = h; m_mask = m;
         end
      end
      @(negedge clk);
   endtask

   task automatic check_model(input string tag);
      check({tag, ".s"}, {14'd0, s}, {14'd0, m_s()});
      check({tag, ".an"}, {12'd0, an}, {12'd0, m_an()});
      check({tag, ".I"}, {I3, I2, I1, I0}, m_word);
      check({tag, ".tick"}, {15'd0, tick}, {15'd0, m_tick});
   endtask

   task automatic run_to(input int phase);
      int guard;
      guard = 0;
      while ((m_n % 16) != phase && guard < 64) begin
         step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
         guard++;
      end
      check("run_to_phase", 16'(m_n % 16), 16'(phase));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; load = 1'b0; hex = '0; blank_mask = '0; hold = 1'b0;
      m_n = 0; m_tick = 1'b0; m_word = '0; m_mask = '0;
      @(negedge clk);

      // Directed table starting from reset.
      vecs[0]  = mk(1, 0, 16'h0000, 4'h0, 0, 4'hE, 16'h0000, 0);
      vecs[1]  = mk(1, 0, 16'h0000, 4'h0, 0, 4'hE, 16'h0000, 0);
      vecs[2]  = mk(0, 0, 16'h0000, 4'h0, 0, 4'hE, 16'h0000, 0);
      vecs[3]  = mk(0, 1, 16'h3210, 4'h0, 0, 4'hE, 16'h3210, 0);
      vecs[4]  = mk(0, 0, 16'h0000, 4'h0, 0, 4'hE, 16'h3210, 0);
      vecs[5]  = mk(0, 0, 16'h0000, 4'h0, 1, 4'hD, 16'h3210, 1);
      vecs[6]  = mk(0, 1, 16'hA5A5, 4'h4, 1, 4'hD, 16'hA5A5, 0);
      vecs[7]  = mk(0, 0, 16'h0000, 4'h0, 1, 4'hD, 16'hA5A5, 0);
      vecs[8]  = mk(0, 0, 16'h0000, 4'h0, 1, 4'hD, 16'hA5A5, 0);
      vecs[9]  = mk(0, 0, 16'h0000, 4'h0, 2, 4'hF, 16'hA5A5, 1);
      vecs[10] = mk(0, 0, 16'h0000, 4'h0, 2, 4'hF, 16'hA5A5, 0);
      vecs[11] = mk(0, 0, 16'h0000, 4'h0, 2, 4'hF, 16'hA5A5, 0);
      vecs[12] = mk(0, 0, 16'h0000, 4'h0, 2, 4'hF, 16'hA5A5, 0);
      // Load on the advancing edge: new digit and new mask together.
      vecs[13] = mk(0, 1, 16'hBEEF, 4'h8, 3, 4'hF, 16'hBEEF, 1);
      vecs[14] = mk(0, 0, 16'h0000, 4'h0, 3, 4'hF, 16'hBEEF, 0);
      vecs[15] = mk(0, 0, 16'h0000, 4'h0, 3, 4'hF, 16'hBEEF, 0);
      vecs[16] = mk(0, 0, 16'h0000, 4'h0, 3, 4'hF, 16'hBEEF, 0);
      vecs[17] = mk(0, 0, 16'h0000, 4'h0, 0, 4'hE, 16'hBEEF, 1);
      vecs[18] = mk(0, 0, 16'h0000, 4'h0, 0, 4'hE, 16'hBEEF, 0);

      for (int i = 0; i < 19; i++) begin
         step(vecs[i].rst, vecs[i].load, vecs[i].hex, vecs[i].mask, 1'b0);
         check($sformatf("vec%0d.s", i), {14'd0, s}, {14'd0, vecs[i].exp_s});
         check($sformatf("vec%0d.an", i), {12'd0, an}, {12'd0, vecs[i].exp_an});
         check($sformatf("vec%0d.I", i), {I3, I2, I1, I0}, vecs[i].exp_word);
         check($sformatf("vec%0d.tick", i), {15'd0, tick}, {15'd0, vecs[i].exp_tick});
      end

      // Reset mid-scan at s=2, div=1: everything returns to reset values.
      run_to(9);
      check("mid.s_before", {14'd0, s}, 16'd2);
      step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
      check("mid_rst.s", {14'd0, s}, 16'd0);
      check("mid_rst.I", {I3, I2, I1, I0}, 16'h0000);
      check("mid_rst.an", {12'd0, an}, 16'hE);
      check("mid_rst.tick", {15'd0, tick}, 16'd0);
      for (int i = 1; i <= 4; i++) begin
         step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
         check($sformatf("post_rst%0d.tick", i), {15'd0, tick}, {15'd0, (i == 4)});
         check($sformatf("post_rst%0d.s", i), {14'd0, s}, (i == 4) ? 16'd1 : 16'd0);
      end

`ifdef SCAN_HOLD_EN
      // Hold at s=1, div=1 for 10 cycles, with a load still accepted.
      run_to(5);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, (i == 3), 16'h4321, 4'h0, 1'b1);
         check($sformatf("hold%0d.s", i), {14'd0, s}, 16'd1);
         check($sformatf("hold%0d.tick", i), {15'd0, tick}, 16'd0);
      end
      check("hold.load", {I3, I2, I1, I0}, 16'h4321);
      for (int i = 1; i <= 3; i++) begin
         step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
         check($sformatf("release%0d.s", i), {14'd0, s}, (i == 3) ? 16'd2 : 16'd1);
         check($sformatf("release%0d.tick", i), {15'd0, tick}, {15'd0, (i == 3)});
      end
`endif

      // Random stimulus against the model.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
              16'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0));
         check_model($sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
